mem_stage_hs: RTL and testbench

Memory stage for the pipelined MIPS core with a variable-latency data SRAM (request/`data_ok` handshake), replacing the fixed one-cycle memory stage. It sits between EXE and WB. It waits for load data and buffers it while WB stalls. It sign- or zero-extends sub-word loads and carries exception information to WB. It drops or cancels in-flight loads on a pipeline flush, and exports a forwarding/blocking view for ID.

---
 rtl/mem_stage_hs_pkg.sv | 34 +++
 rtl/mem_stage_hs_load_align.sv | 48 ++++
 rtl/mem_stage_hs.sv | 164 ++++++++++++++++
 tb/tb_mem_stage_hs.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_hs_pkg.sv
// Shared definitions for the handshaked memory stage: bus widths, load-op
// encodings and the stage FSM states.
package mem_stage_hs_pkg;

    // Bus widths excluding the exception-code field, which is parameterised.
    localparam int MS_IN_FIXED_W  = 76;
    localparam int MS_OUT_FIXED_W = 103;
    localparam int MS_FWD_W       = 39;

    typedef enum logic [2:0] {
        LD_LW  = 3'b000,
        LD_LB  = 3'b001,
        LD_LBU = 3'b010,
        LD_LH  = 3'b011,
        LD_LHU = 3'b100,
        LD_LD  = 3'b101
    } ld_op_e;

    typedef enum logic [1:0] {
        MS_EMPTY  = 2'd0,
        MS_WAIT   = 2'd1,
        MS_READY  = 2'd2,
        MS_CANCEL = 2'd3
    } ms_state_e;

    // State entered when EXE hands over an instruction (or nothing).
    function automatic ms_state_e accept_state(input logic valid, input logic req_sent);
        if (!valid) begin
            return MS_EMPTY;
        end
        return req_sent ? MS_WAIT : MS_READY;
    endfunction

endpackage

// File: rtl/mem_stage_hs_load_align.sv
// Load lane select and sign/zero extension: picks the addressed byte,
// halfword or word out of an SRAM data word and widens it to 32 bits.
module mem_stage_hs_load_align
    import mem_stage_hs_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [2:0]        ld_op_i,
    output logic [31:0]       result_o
);

    localparam int IDX_W = OFF_W + 3;
    // Clearing low index bits aligns the bit index down to the access size.
    localparam logic [IDX_W-1:0] HALF_MASK = ~IDX_W'(15);
    localparam logic [IDX_W-1:0] WORD_MASK = ~IDX_W'(31);

    logic [IDX_W-1:0] byte_idx;
    logic [IDX_W-1:0] half_idx;
    logic [IDX_W-1:0] word_idx;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [31:0]      word_v;

    assign byte_idx = {off_i, 3'b000};
    assign half_idx = byte_idx & HALF_MASK;
    assign word_idx = byte_idx & WORD_MASK;

    assign byte_v = rdata_i[byte_idx +: 8];
    assign half_v = rdata_i[half_idx +: 16];
    assign word_v = rdata_i[word_idx +: 32];

    always_comb begin
        // NOTE: assign a default before the case so no path leaves the output
        // unassigned, which would infer a latch.
        result_o = word_v;
        case (ld_op_i)
            LD_LB:   result_o = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  result_o = {24'b0, byte_v};
            LD_LH:   result_o = {{16{half_v[15]}}, half_v};
            LD_LHU:  result_o = {16'b0, half_v};
            default: result_o = word_v;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// MIPS memory stage for a variable-latency data SRAM: waits for data_ok,
// buffers load data while WB stalls, cancels owed responses on flush.
module mem_stage_hs
    import mem_stage_hs_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int OFF_W     = $clog2(DATA_W / 8),
    parameter int EXCODE_W  = 5,
    parameter int MS_IN_WD  = MS_IN_FIXED_W + EXCODE_W,
    parameter int MS_OUT_WD = MS_OUT_FIXED_W + EXCODE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ws_allowin,
    output logic                 ms_allowin,
    input  logic                 es_to_ms_valid,
    input  logic [MS_IN_WD-1:0]  es_to_ms_bus,
    output logic                 ms_to_ws_valid,
    output logic [MS_OUT_WD-1:0] ms_to_ws_bus,
    input  logic                 data_sram_data_ok,
    input  logic [DATA_W-1:0]    data_sram_rdata,
    input  logic                 ms_flush,
    output logic                 ms_ex_block,
    output logic [MS_FWD_W-1:0]  ms_fwd_bus
);

    // Incoming EXE bus fields.
    logic                es_req_sent;
    logic [2:0]          es_ld_op;
    logic                es_res_from_mem;
    logic                es_gr_we;
    logic [4:0]          es_dest;
    logic                es_ex;
    logic [EXCODE_W-1:0] es_excode;
    logic [31:0]         es_alu_result;
    logic [31:0]         es_pc;

    assign {es_req_sent, es_ld_op, es_res_from_mem, es_gr_we, es_dest,
            es_ex, es_excode, es_alu_result, es_pc} = es_to_ms_bus;

    ms_state_e           state_q;
    ms_state_e           state_d;
    logic [2:0]          ld_op_q;
    logic                res_from_mem_q;
    logic                gr_we_q;
    logic [4:0]          dest_q;
    logic                ex_q;
    logic [EXCODE_W-1:0] excode_q;
    logic [31:0]         alu_result_q;
    logic [31:0]         pc_q;
    logic [DATA_W-1:0]   rdata_buf_q;

    logic              ms_valid;
    logic              ms_ready_go;
    logic              accept;
    logic              buf_load;
    logic [DATA_W-1:0] rdata_sel;
    logic [31:0]       load_result;
    logic [31:0]       final_result;
    logic              fwd_valid;
    logic              fwd_blocked;

    assign ms_valid    = (state_q == MS_WAIT) || (state_q == MS_READY);
    assign ms_ready_go = (state_q == MS_READY) ||
                         ((state_q == MS_WAIT) && data_sram_data_ok);
    // CANCEL never reaches ready_go, so allowin stays low until the owed data_ok.
    assign ms_allowin  = (state_q == MS_EMPTY) || (ms_ready_go && ws_allowin);
    assign accept      = ms_allowin && es_to_ms_valid && !ms_flush;

    assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;
    assign buf_load       = (state_q == MS_WAIT) && data_sram_data_ok &&
                            !ws_allowin && !ms_flush;

    always_comb begin
        state_d = state_q;
        if (ms_flush) begin
            if (((state_q == MS_WAIT) || (state_q == MS_CANCEL)) && !data_sram_data_ok) begin
                state_d = MS_CANCEL;
            end else begin
                state_d = MS_EMPTY;
            end
        end else begin
            case (state_q)
                MS_EMPTY: begin
                    state_d = accept_state(es_to_ms_valid, es_req_sent);
                end
                MS_WAIT: begin
                    if (data_sram_data_ok) begin
                        state_d = ws_allowin ? accept_state(es_to_ms_valid, es_req_sent)
                                             : MS_READY;
                    end
                end
                MS_READY: begin
                    if (ws_allowin) begin
                        state_d = accept_state(es_to_ms_valid, es_req_sent);
                    end
                end
                MS_CANCEL: begin
                    if (data_sram_data_ok) begin
                        state_d = MS_EMPTY;
                    end
                end
                default: state_d = MS_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the same
        // pre-edge values regardless of statement order.
        if (reset) begin
            state_q        <= MS_EMPTY;
            ld_op_q        <= '0;
            res_from_mem_q <= 1'b0;
            gr_we_q        <= 1'b0;
            dest_q         <= '0;
            ex_q           <= 1'b0;
            excode_q       <= '0;
            alu_result_q   <= '0;
            pc_q           <= '0;
            rdata_buf_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ld_op_q        <= es_ld_op;
                res_from_mem_q <= es_res_from_mem;
                gr_we_q        <= es_gr_we;
                dest_q         <= es_dest;
                ex_q           <= es_ex;
                excode_q       <= es_excode;
                alu_result_q   <= es_alu_result;
                pc_q           <= es_pc;
            end
            if (buf_load) begin
                rdata_buf_q <= data_sram_rdata;
            end
        end
    end

    // Live SRAM data while waiting; the buffer once the stage has gone READY.
    assign rdata_sel = (state_q == MS_WAIT) ? data_sram_rdata : rdata_buf_q;

    mem_stage_hs_load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_load_align (
        .rdata_i  (rdata_sel),
        .off_i    (alu_result_q[OFF_W-1:0]),
        .ld_op_i  (ld_op_q),
        .result_o (load_result)
    );

    assign final_result = res_from_mem_q ? load_result : alu_result_q;

    assign ms_to_ws_bus = {gr_we_q, dest_q, final_result, ex_q, excode_q,
                           alu_result_q, pc_q};

    assign ms_ex_block = ms_valid && ex_q;

    assign fwd_valid   = ms_valid && gr_we_q;
    assign fwd_blocked = fwd_valid && res_from_mem_q && !ms_ready_go;
    assign ms_fwd_bus  = {fwd_valid, fwd_blocked, dest_q, final_result};

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs: a 32-bit and a 64-bit instance share
// stimulus; expected WB transfers are queued when driven and popped on handshake.
module tb_mem_stage_hs;
    import mem_stage_hs_pkg::*;

    localparam int IN_W  = 81;
    localparam int OUT_W = 108;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            ws_allowin;
    logic            es_to_ms_valid;
    logic [IN_W-1:0] es_bus;
    logic            data_ok;
    logic [63:0]     rdata;
    logic            ms_flush;

    logic             allowin32, v32, exblk32;
    logic [OUT_W-1:0] bus32;
    logic [38:0]      fwd32;
    logic             allowin64, v64, exblk64;
    logic [OUT_W-1:0] bus64;
    logic [38:0]      fwd64;

    mem_stage_hs #(.DATA_W(32)) u_dut32 (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (allowin32),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_bus),
        .ms_to_ws_valid    (v32),
        .ms_to_ws_bus      (bus32),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata[31:0]),
        .ms_flush          (ms_flush),
        .ms_ex_block       (exblk32),
        .ms_fwd_bus        (fwd32)
    );

    mem_stage_hs #(.DATA_W(64)) u_dut64 (
        .clk               (clk),
        .reset             (reset),
        .ws_allowin        (ws_allowin),
        .ms_allowin        (allowin64),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_bus),
        .ms_to_ws_valid    (v64),
        .ms_to_ws_bus      (bus64),
        .data_sram_data_ok (data_ok),
        .data_sram_rdata   (rdata),
        .ms_flush          (ms_flush),
        .ms_ex_block       (exblk64),
        .ms_fwd_bus        (fwd64)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [OUT_W-1:0] q32[$];
    logic [OUT_W-1:0] q64[$];
    bit  mon32_en = 1'b1;
    int  owed = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [IN_W-1:0] mk_in(input logic req, input logic [2:0] op,
        input logic rfm, input logic we, input logic [4:0] dest, input logic ex,
        input logic [4:0] exc, input logic [31:0] alu, input logic [31:0] pc);
        return {req, op, rfm, we, dest, ex, exc, alu, pc};
    endfunction

    function automatic logic [OUT_W-1:0] mk_out(input logic we, input logic [4:0] dest,
        input logic [31:0] res, input logic ex, input logic [4:0] exc,
        input logic [31:0] bad, input logic [31:0] pc);
        return {we, dest, res, ex, exc, bad, pc};
    endfunction

    task automatic expect_wb(input logic [OUT_W-1:0] e, input bit to32);
        q64.push_back(e);
        if (to32) q32.push_back(e);
    endtask

    task automatic neg();
        @(negedge clk);
    endtask

    task automatic pos();
        @(posedge clk);
        #1;
    endtask

    // WB handshake monitor: every transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (v64 && ws_allowin) begin
                if (q64.size() == 0) check("wb64_unexpected", 1'b1, 1'b0);
                else check("wb64_bus", bus64, q64.pop_front());
            end
            if (mon32_en && v32 && ws_allowin) begin
                if (q32.size() == 0) check("wb32_unexpected", 1'b1, 1'b0);
                else check("wb32_bus", bus32, q32.pop_front());
            end
        end
    end

    // SRAM-side bookkeeping: data_ok is only legal while a response is owed.
    always @(posedge clk) begin
        if (reset) begin
            owed <= 0;
        end else begin
            if (data_ok) check("proto_data_ok_owed", owed > 0, 1'b1);
            owed <= owed
                  + ((es_to_ms_valid && allowin64 && !ms_flush && es_bus[IN_W-1]) ? 1 : 0)
                  - ((data_ok && owed > 0) ? 1 : 0);
        end
    end

    task automatic load_txn(input string tag, input logic [2:0] op, input logic [31:0] alu,
        input logic [63:0] rd, input int lat, input logic [31:0] exp_res, input bit to32);
        es_to_ms_valid = 1'b1;
        es_bus = mk_in(1'b1, op, 1'b1, 1'b1, 5'd3, 1'b0, 5'd0, alu, 32'hBFC0_0040);
        expect_wb(mk_out(1'b1, 5'd3, exp_res, 1'b0, 5'd0, alu, 32'hBFC0_0040), to32);
        neg(); check({tag, "_accept_allowin"}, allowin64, 1'b1);
        pos(); es_to_ms_valid = 1'b0;
        for (int i = 1; i < lat; i++) begin
            neg(); check({tag, "_wait"}, {v64, allowin64, fwd64[38:37]}, 4'b0011);
            pos();
        end
        data_ok = 1'b1;
        rdata   = rd;
        neg(); check({tag, "_pulse_fwd"}, {v64, fwd64}, {1'b1, 1'b1, 1'b0, 5'd3, exp_res});
        pos(); data_ok = 1'b0; rdata = '0;
        neg(); check({tag, "_done"}, {v64, allowin64}, 2'b01);
        pos();
    endtask

    initial begin
        reset = 1'b1; ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_bus = '0;
        data_ok = 1'b0; rdata = '0; ms_flush = 1'b0;
        pos(); pos();
        reset = 1'b0;
        neg();
        check("rst_allowin", {allowin32, allowin64}, 2'b11);
        check("rst_valid", {v32, v64}, 2'b00);
        check("rst_exblock", {exblk32, exblk64}, 2'b00);
        check("rst_fwd_valid", {fwd32[38], fwd64[38]}, 2'b00);
        pos();

        // Sub-word loads, data_ok three cycles after accept, WB always ready.
        load_txn("lb",  LD_LB,  32'h0000_1003, 64'h0000_0000_80FF_1234, 3, 32'hFFFF_FF80, 1'b1);
        load_txn("lbu", LD_LBU, 32'h0000_1003, 64'h0000_0000_80FF_1234, 3, 32'h0000_0080, 1'b1);

        // LH with data_ok while WB stalls; result must come from the buffer.
        es_to_ms_valid = 1'b1;
        es_bus = mk_in(1'b1, LD_LH, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 32'h0000_2002, 32'hBFC0_0080);
        expect_wb(mk_out(1'b1, 5'd9, 32'hFFFF_8001, 1'b0, 5'd0, 32'h0000_2002, 32'hBFC0_0080), 1'b1);
        pos();
        es_to_ms_valid = 1'b0; ws_allowin = 1'b0; data_ok = 1'b1; rdata = 64'h0000_0000_8001_5678;
        neg(); check("lh_dataok_allowin", {allowin64, allowin32}, 2'b00);
        pos();
        data_ok = 1'b0; rdata = 64'hFFFF_FFFF_0000_0000;
        for (int i = 0; i < 4; i++) begin
            neg(); check("lh_hold", {v64, allowin64, allowin32}, 3'b100);
            pos();
        end
        ws_allowin = 1'b1;
        neg(); check("lh_release", {v64, allowin64}, 2'b11);
        pos(); rdata = '0;
        neg(); check("lh_after", {v64, allowin64}, 2'b01);
        pos();

        // Flush in the first WAIT cycle; owed data arrives two cycles later.
        es_to_ms_valid = 1'b1;
        es_bus = mk_in(1'b1, LD_LW, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 32'h0000_3000, 32'hBFC0_00C0);
        pos();
        es_to_ms_valid = 1'b0; ms_flush = 1'b1;
        neg(); check("flush_wait_nowb", {v64, v32, allowin64}, 3'b000);
        pos();
        ms_flush = 1'b0; es_to_ms_valid = 1'b1;
        es_bus = mk_in(1'b0, LD_LW, 1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'h0000_0042, 32'hBFC0_00C4);
        neg(); check("cancel_allowin", {allowin64, allowin32, v64}, 3'b000);
        pos();
        data_ok = 1'b1; rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        neg(); check("cancel_dataok", {allowin64, allowin32, v64, v32}, 4'b0000);
        pos();
        data_ok = 1'b0; rdata = '0;
        expect_wb(mk_out(1'b1, 5'd7, 32'h0000_0042, 1'b0, 5'd0, 32'h0000_0042, 32'hBFC0_00C4), 1'b1);
        neg(); check("post_cancel_allowin", {allowin64, allowin32}, 2'b11);
        pos();
        es_to_ms_valid = 1'b0;
        neg(); check("addu_after_cancel", {v64, fwd64}, {1'b1, 1'b1, 1'b0, 5'd7, 32'h0000_0042});
        pos();

        // Flush and data_ok in the same cycle: straight to EMPTY.
        es_to_ms_valid = 1'b1;
        es_bus = mk_in(1'b1, LD_LW, 1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 32'h0000_4000, 32'hBFC0_0100);
        pos();
        es_to_ms_valid = 1'b0; ms_flush = 1'b1; data_ok = 1'b1; rdata = 64'h5555_5555_5555_5555;
        neg(); check("flush_dok_nowb", {v64, v32}, 2'b00);
        pos();
        ms_flush = 1'b0; data_ok = 1'b0; rdata = '0;
        neg(); check("flush_dok_empty", {allowin64, allowin32, v64}, 3'b110);
        pos();

        // Exception-carrying instruction.
        es_to_ms_valid = 1'b1;
        es_bus = mk_in(1'b0, LD_LW, 1'b0, 1'b0, 5'd0, 1'b1, 5'h04, 32'h0000_1001, 32'hBFC0_0140);
        expect_wb(mk_out(1'b0, 5'd0, 32'h0000_1001, 1'b1, 5'h04, 32'h0000_1001, 32'hBFC0_0140), 1'b1);
        neg(); check("ex_pre_block", exblk64, 1'b0);
        pos();
        es_to_ms_valid = 1'b0;
        neg(); check("ex_resident", {v64, exblk64, exblk32, fwd64[38]}, 4'b1110);
        pos();
        neg(); check("ex_gone", {v64, exblk64}, 2'b00);
        pos();

        // Back-to-back non-memory instructions, one cycle each.
        for (int i = 0; i < 4; i++) begin
            es_to_ms_valid = 1'b1;
            es_bus = mk_in(1'b0, LD_LW, 1'b0, 1'b1, 5'(10 + i), 1'b0, 5'd0,
                           32'hA000_0000 + 32'(i), 32'hBFC0_0200 + 32'(4 * i));
            expect_wb(mk_out(1'b1, 5'(10 + i), 32'hA000_0000 + 32'(i), 1'b0, 5'd0,
                             32'hA000_0000 + 32'(i), 32'hBFC0_0200 + 32'(4 * i)), 1'b1);
            neg(); check("stream_allowin", {allowin64, allowin32}, 2'b11);
            pos();
        end
        es_to_ms_valid = 1'b0;
        neg(); check("stream_tail", v64, 1'b1);
        pos();

        // Reset while a load is outstanding.
        es_to_ms_valid = 1'b1;
        es_bus = mk_in(1'b1, LD_LB, 1'b1, 1'b1, 5'd6, 1'b0, 5'd0, 32'h0000_5000, 32'hBFC0_0300);
        pos();
        es_to_ms_valid = 1'b0;
        neg(); check("rst_pre_wait", allowin64, 1'b0);
        pos();
        reset = 1'b1;
        pos();
        reset = 1'b0;
        neg(); check("rst_mid_wait", {allowin64, allowin32, v64, v32}, 4'b1100);
        pos();

        // 64-bit LD at offset 4 (64-bit instance only).
        mon32_en = 1'b0;
        load_txn("ld64", LD_LD, 32'h0000_1004, 64'h1111_2222_3333_4444, 2, 32'h1111_2222, 1'b0);

        check("sb64_drained", 32'(q64.size()), 32'd0);
        check("sb32_drained", 32'(q32.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
